shiftregister_deserializer_right: RTL and testbench
===================================================

# shiftregister_deserializer_right

Serial-in/parallel-out receiver: the receiving end of the right-shifting circular register's serial stream. It captures WIDTH bits arriving LSB-first on `serial_in` and reassembles them into the original parallel word. When the frame completes, it presents the word with a one-cycle valid strobe. It sits at the sink of any right-shift link in the lab datapath, typically fed from the transmitter's `signal_q[0]`.

## Interface
Parameters:
- `WIDTH`, default 5: frame length in bits; legal range 2..8.

Ports:
- `clockpulse`  input  1  single clock; all state updates on the rising edge.
- `clear`  input  1  reset, synchronous, active-low; sampled on the rising edge of `clockpulse`.
- `start`  input  1  frame start request; begins a new frame.
- `shift_enable`  input  1  qualifies `serial_in`; one bit is accepted per cycle in which it is high.
- `serial_in`  input  1  serial data, LSB first.
- `data_out`  output  WIDTH  last completed word; held until the next completion.
- `data_valid`  output  1  one-cycle pulse when `data_out` updates.
- `busy`  output  1  high while in RECEIVE.
- `frame_error`  output  1  one-cycle pulse when a frame is aborted by `start`.
- `bit_count`  output  3  number of bits accepted in the current frame.

## Operation
- Reset: when `clear`=0 at an edge, the following are forced regardless of other inputs:
  - state to IDLE;
  - shift register, `data_out`, `bit_count` to 0;
  - `data_valid`, `busy`, `frame_error` to 0.
- States: IDLE, RECEIVE.
- IDLE:
  - `start`=1 leads to RECEIVE with `bit_count`=0 and the shift register cleared.
  - `shift_enable` is ignored while in IDLE.
  - `start` and `shift_enable` high in the same IDLE cycle: only the start is taken; the bit is not captured.
- RECEIVE, with `shift_enable`=1 and `start`=0:
  - shift register updates to {`serial_in`, sr[WIDTH-1:1]} (right shift, new bit at MSB);
  - `bit_count` increments.
- RECEIVE, with `shift_enable`=0: all state is held; gaps of any length are allowed.
- Completion: when the accepted bit is the WIDTH-th, at that same edge:
  - `data_out` loads {`serial_in`, sr[WIDTH-1:1]};
  - `data_valid` goes to 1;
  - `bit_count` goes to 0;
  - state returns to IDLE.
- Bit ordering: the first bit received lands in `data_out[0]`, and the last lands in `data_out[WIDTH-1]`.
- Abort: `start`=1 while in RECEIVE:
  - `frame_error` pulses;
  - shift register and `bit_count` clear;
  - state stays RECEIVE (restart);
  - any `shift_enable` in that cycle is discarded;
  - `data_out` is unchanged.
- Abort is checked before completion: `start`=1 on the cycle of the WIDTH-th bit gives an abort, not a completion.
- `data_out` is never cleared except by reset.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Latency: `data_valid` is high in the cycle immediately after the edge that sampled the WIDTH-th bit.
- `data_valid` and `frame_error` are single-cycle pulses; they are never high together.
- `busy` rises on the edge after `start` is sampled in IDLE and falls on the completion edge. `busy`=0 in the `data_valid` cycle.
- Back-to-back frames:
  - `start` may be asserted in the `data_valid` cycle; the FSM is already in IDLE.
  - Minimum frame period is WIDTH+1 cycles.
- Reset mid-frame discards the partial frame; no `data_valid` or `frame_error` is produced.
- `bit_count` range is 0..WIDTH-1 as observed. It reads WIDTH-1 only after WIDTH-1 bits have been accepted.

## Test plan
- Reset: hold `clear`=0 for 2 cycles with random inputs toggling → all outputs 0, `busy`=0.
- Basic frame, WIDTH=5:
  - stimulus: `start`, then 5 cycles of `shift_enable`=1 with `serial_in` = 1,0,1,1,0;
  - required: `data_out`=5'b01101 and `data_valid` high for exactly one cycle, 6 cycles after `start`.
- Loopback: 5-bit circular right shifter preset to 5'b10011, shifted 5 times, with its `signal_q[0]` driving `serial_in` → `data_out`=5'b10011.
- Gaps: same bits as the basic frame with `shift_enable` low for 3 cycles between bits 2 and 3 → `data_out`=5'b01101; `bit_count` holds at 2 during the gap.
- Abort:
  - stimulus: `start` reasserted after 3 bits, then 5 bits 1,1,1,1,1;
  - required: `frame_error` pulses once, then `data_out`=5'b11111;
  - required: no `data_valid` for the aborted frame.
- Reset mid-frame: `clear`=0 after 4 bits → no `data_valid`, `busy`=0, `data_out` reads 0 after reset.

Source files
------------

// File: rtl/shiftregister_deserializer_right_if.sv
// Bus bundle for the right-shift serial receiver: frame control and serial
// data in, reassembled word plus status out.
interface shiftregister_deserializer_right_if #(
   parameter int WIDTH = 5
);
   logic             start;
   logic             shift_enable;
   logic             serial_in;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             busy;
   logic             frame_error;
   logic [2:0]       bit_count;

   // Side that drives the serial stream (transmitter / testbench)
   modport master (
      output start, shift_enable, serial_in,
      input  data_out, data_valid, busy, frame_error, bit_count
   );

   // Receiver side
   modport slave (
      input  start, shift_enable, serial_in,
      output data_out, data_valid, busy, frame_error, bit_count
   );
endinterface

// File: rtl/shiftregister_deserializer_right.sv
// Serial-in/parallel-out receiver for a right-shifting link. Bits arrive
// LSB first and are shifted in at the MSB, so after WIDTH accepted bits the
// first bit sits in bit 0. A restart during a frame flags frame_error.
module shiftregister_deserializer_right #(
   parameter int WIDTH = 5
) (
   input logic                             clockpulse,
   input logic                             clear,
   shiftregister_deserializer_right_if.slave bus
);

   typedef enum logic {
      S_IDLE,
      S_RECEIVE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_data_out;
   logic [2:0]       r_bit_count;
   logic             r_data_valid;
   logic             r_busy;
   logic             r_frame_error;

   logic [WIDTH-1:0] w_sr_next;
   logic             w_last_bit;

   assign w_sr_next  = {bus.serial_in, r_sr[WIDTH-1:1]};
   assign w_last_bit = (r_bit_count == 3'(WIDTH - 1));

   // Frame FSM with registered outputs; abort has priority over completion
   always_ff @(posedge clockpulse) begin
      if (!clear) begin
         r_state       <= S_IDLE;
         r_sr          <= '0;
         r_data_out    <= '0;
         r_bit_count   <= '0;
         r_data_valid  <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_data_valid  <= 1'b0;
         r_frame_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state     <= S_RECEIVE;
                  r_sr        <= '0;
                  r_bit_count <= '0;
                  r_busy      <= 1'b1;
               end
            end
            S_RECEIVE: begin
               if (bus.start) begin
                  r_frame_error <= 1'b1;
                  r_sr          <= '0;
                  r_bit_count   <= '0;
               end else if (bus.shift_enable) begin
                  r_sr <= w_sr_next;
                  if (w_last_bit) begin
                     r_data_out   <= w_sr_next;
                     r_data_valid <= 1'b1;
                     r_bit_count  <= '0;
                     r_busy       <= 1'b0;
                     r_state      <= S_IDLE;
                  end else begin
                     r_bit_count <= r_bit_count + 3'd1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out    = r_data_out;
   assign bus.data_valid  = r_data_valid;
   assign bus.busy        = r_busy;
   assign bus.frame_error = r_frame_error;
   assign bus.bit_count   = r_bit_count;

endmodule

// File: tb/tb_shiftregister_deserializer_right.sv
// Scoreboard bench for the right-shift deserializer: a driver issues stimulus
// and updates a bit-list reference model, a monitor compares every cycle.
module tb_shiftregister_deserializer_right;
   localparam int W = 5;

   logic clk = 1'b0;
   logic clear;
   always #5 clk = ~clk;

   shiftregister_deserializer_right_if #(.WIDTH(W)) bus ();

   shiftregister_deserializer_right #(.WIDTH(W)) dut (
      .clockpulse(clk),
      .clear     (clear),
      .bus       (bus.slave)
   );

   typedef struct {
      bit           err;
      logic [W-1:0] data;
   } ev_t;

   ev_t          ev_q[$];
   int           m_bits[$];
   bit           m_busy;
   logic [W-1:0] m_dout;
   bit           mon_en = 1'b0;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame = list of received bits; word = sum of bit_i * 2^i
   task automatic model_update(input logic c, input logic s, input logic e, input logic d);
      logic [W-1:0] word;
      ev_t          ev;
      if (!c) begin
         m_busy = 1'b0;
         m_bits.delete();
         m_dout = '0;
      end else if (!m_busy) begin
         if (s) begin
            m_busy = 1'b1;
            m_bits.delete();
         end
      end else if (s) begin
         ev.err  = 1'b1;
         ev.data = m_dout;
         ev_q.push_back(ev);
         m_bits.delete();
      end else if (e) begin
         m_bits.push_back(int'(d));
         if (m_bits.size() == W) begin
            word = '0;
            for (int i = 0; i < W; i++)
               if (m_bits[i] != 0) word = word + W'(1 << i);
            m_dout  = word;
            ev.err  = 1'b0;
            ev.data = word;
            ev_q.push_back(ev);
            m_busy = 1'b0;
            m_bits.delete();
         end
      end
   endtask

   task automatic cycle(input logic c, input logic s, input logic e, input logic d);
      clear            = c;
      bus.start        = s;
      bus.shift_enable = e;
      bus.serial_in    = d;
      @(posedge clk);
      model_update(c, s, e, d);
      #1;
   endtask

   task automatic send_bits(input logic [W-1:0] bits);
      for (int i = 0; i < W; i++) cycle(1'b1, 1'b0, 1'b1, bits[i]);
   endtask

   // Monitor: per-cycle status compare and pulse scoreboard
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("bit_count", 32'(bus.bit_count), 32'(m_bits.size()));
            check("data_out", 32'(bus.data_out), 32'(m_dout));
            if (bus.data_valid && bus.frame_error)
               check("pulse_overlap", 32'(1), 32'(0));
            if (ev_q.size() == 0) begin
               check("spurious_pulse", 32'({bus.data_valid, bus.frame_error}), 32'(0));
            end else begin
               e = ev_q.pop_front();
               check("data_valid", 32'(bus.data_valid), 32'(!e.err));
               check("frame_error", 32'(bus.frame_error), 32'(e.err));
               check("event_data", 32'(bus.data_out), 32'(e.data));
            end
         end
      end
   end

   initial begin
      logic [W-1:0] lb;
      // Reset with random inputs toggling
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      mon_en = 1'b1;
      check("rst_data_out", 32'(bus.data_out), 32'(0));
      check("rst_busy", 32'(bus.busy), 32'(0));
      check("rst_bit_count", 32'(bus.bit_count), 32'(0));
      check("rst_pulses", 32'({bus.data_valid, bus.frame_error}), 32'(0));

      // Basic frame: bits 1,0,1,1,0 -> 01101
      cycle(1'b1, 1'b1, 1'b1, 1'b1);   // start with shift_enable: bit ignored
      send_bits(5'b01101);
      check("basic_word", 32'(bus.data_out), 32'(5'b01101));
      check("basic_valid", 32'(bus.data_valid), 32'(1));
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("basic_valid_once", 32'(bus.data_valid), 32'(0));

      // Loopback from a circular right shifter preset to 10011
      lb = 5'b10011;
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < W; i++) begin
         cycle(1'b1, 1'b0, 1'b1, lb[0]);
         lb = {lb[0], lb[W-1:1]};
      end
      check("loopback_word", 32'(bus.data_out), 32'(5'b10011));

      // Gap of 3 cycles after bit 2; start in data_valid cycle (back-to-back)
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'($urandom));
         check("gap_bit_count", 32'(bus.bit_count), 32'(2));
      end
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      check("bit_count_max", 32'(bus.bit_count), 32'(W - 1));
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check("gap_word", 32'(bus.data_out), 32'(5'b01101));

      // Abort after 3 bits, then 5 ones
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      check("abort_error", 32'(bus.frame_error), 32'(1));
      check("abort_dout_kept", 32'(bus.data_out), 32'(5'b01101));
      check("abort_busy", 32'(bus.busy), 32'(1));
      send_bits(5'b11111);
      check("abort_word", 32'(bus.data_out), 32'(5'b11111));

      // Start on the WIDTH-th bit: abort wins over completion
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < W - 1; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("late_abort_valid", 32'(bus.data_valid), 32'(0));
      check("late_abort_error", 32'(bus.frame_error), 32'(1));

      // Reset mid-frame after 4 bits
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check("midrst_busy", 32'(bus.busy), 32'(0));
      check("midrst_dout", 32'(bus.data_out), 32'(0));
      check("midrst_valid", 32'(bus.data_valid), 32'(0));

      // Randomized traffic
      for (int i = 0; i < 1500; i++)
         cycle(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom));

      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("queue_drained", 32'(ev_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
